// File: rtl/multichannel_decimator.sv
`default_nettype none
// ============================================================================
// multichannel_decimator
// TDM runtime-configurable decimator: per-channel counters feed an output FIFO
// with valid/ready backpressure.
// Rev 1.0
// ============================================================================
module multichannel_decimator #(
   parameter int WordLengthBits          = 29,
   parameter int NumChannels             = 4,
   parameter int MaxDecimationFactor     = 1024,
   parameter int DefaultDecimationFactor = 50,
   parameter int FifoDepth               = 4,
   localparam int ChanBits   = (NumChannels > 1) ? $clog2(NumChannels) : 1,
   localparam int FactorBits = $clog2(MaxDecimationFactor + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic        [FactorBits-1:0]     cfg_factor,
   input  logic                             cfg_load,
   output logic                             cfg_error,
   input  logic signed [WordLengthBits-1:0] in,
   input  logic        [ChanBits-1:0]       in_chan,
   input  logic                             in_valid,
   output logic                             in_ready,
   output logic signed [WordLengthBits-1:0] out,
   output logic        [ChanBits-1:0]       out_chan,
   output logic                             out_valid,
   input  logic                             out_ready
);

   localparam int PtrBits = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int CntBits = $clog2(FifoDepth + 1);
   localparam logic [FactorBits-1:0] MaxFactor = FactorBits'(MaxDecimationFactor);
   localparam logic [FactorBits-1:0] DefFactor = FactorBits'(DefaultDecimationFactor);
   localparam logic [PtrBits-1:0]    LastSlot  = PtrBits'(FifoDepth - 1);
   localparam logic [CntBits-1:0]    FullCnt   = CntBits'(FifoDepth);

   logic        [FactorBits-1:0]     factor_q, factor_d;
   logic        [FactorBits-1:0]     count_q [NumChannels];
   logic        [FactorBits-1:0]     count_d [NumChannels];
   logic signed [WordLengthBits-1:0] mem_data_q [FifoDepth];
   logic        [ChanBits-1:0]       mem_chan_q [FifoDepth];
   logic        [PtrBits-1:0]        wr_ptr_q, rd_ptr_q;
   logic        [CntBits-1:0]        fill_q;
   logic                             cfg_error_q;
   logic                             accept, cfg_ok, push, pop;

   assign in_ready  = (fill_q != FullCnt);
   assign out_valid = (fill_q != '0);
   assign accept    = in_valid && in_ready;
   assign cfg_ok    = cfg_load && (cfg_factor != '0) && (cfg_factor <= MaxFactor);
   assign pop       = out_valid && out_ready;
   assign cfg_error = cfg_error_q;
   // Head is masked so an empty FIFO always presents zeros
   assign out       = out_valid ? mem_data_q[rd_ptr_q] : '0;
   assign out_chan  = out_valid ? mem_chan_q[rd_ptr_q] : '0;

   always_comb begin
      factor_d = factor_q;
      push     = 1'b0;
      for (int c = 0; c < NumChannels; c++) count_d[c] = count_q[c];
      if (cfg_ok) begin
         // A valid reconfiguration swallows any sample accepted alongside it
         factor_d = cfg_factor;
         for (int c = 0; c < NumChannels; c++) count_d[c] = '0;
      end else if (accept) begin
         for (int c = 0; c < NumChannels; c++) begin
            if (in_chan == ChanBits'(c)) begin
               if (count_q[c] == factor_q - 1'b1) begin
                  count_d[c] = '0;
                  push       = 1'b1;
               end else begin
                  count_d[c] = count_q[c] + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         factor_q    <= DefFactor;
         for (int c = 0; c < NumChannels; c++) count_q[c] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_q      <= '0;
         cfg_error_q <= 1'b0;
      end else begin
         factor_q    <= factor_d;
         for (int c = 0; c < NumChannels; c++) count_q[c] <= count_d[c];
         cfg_error_q <= cfg_load && !cfg_ok;
         if (push) wr_ptr_q <= (wr_ptr_q == LastSlot) ? '0 : wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= (rd_ptr_q == LastSlot) ? '0 : rd_ptr_q + 1'b1;
         if (push && !pop)      fill_q <= fill_q + 1'b1;
         else if (pop && !push) fill_q <= fill_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_data_q[wr_ptr_q] <= in;
         mem_chan_q[wr_ptr_q] <= in_chan;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multichannel_decimator.sv
`default_nettype none
// ============================================================================
// tb_multichannel_decimator
// Scoreboard bench: a reference decimation model queues expected outputs.
// Rev 1.0
// ============================================================================
module tb_multichannel_decimator;

   localparam int W   = 29;
   localparam int NCH = 5;
   localparam int CB  = 3;
   localparam int FB  = 11;

   logic                clk = 1'b0;
   logic                rst;
   logic        [FB-1:0] cfg_factor;
   logic                cfg_load;
   logic                cfg_error;
   logic signed [W-1:0] in;
   logic        [CB-1:0] in_chan;
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] out;
   logic        [CB-1:0] out_chan;
   logic                out_valid;
   logic                out_ready;

   multichannel_decimator #(
      .WordLengthBits(W), .NumChannels(NCH), .MaxDecimationFactor(1024),
      .DefaultDecimationFactor(50), .FifoDepth(4)
   ) dut (
      .clk(clk), .rst(rst), .cfg_factor(cfg_factor), .cfg_load(cfg_load),
      .cfg_error(cfg_error), .in(in), .in_chan(in_chan), .in_valid(in_valid),
      .in_ready(in_ready), .out(out), .out_chan(out_chan), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [W-1:0] data;
      logic        [CB-1:0] chan;
      int                  cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0, n_errors = 0;
   int   cyc = 0, out_cnt = 0, err_seen = 0, acc_cnt = 0;
   bit   chk_lat = 1'b0;
   bit   bp_done = 1'b0;
   int   factor_m = 50;
   int   cnt_m[NCH];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (cfg_error) err_seen++;
         if (out_valid && out_ready) begin
            out_cnt++;
            check("sb_has_entry", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               mon_e = sb.pop_front();
               check("out_data", out, mon_e.data);
               check("out_chan", out_chan, mon_e.chan);
               if (chk_lat) check("latency", cyc, mon_e.cyc);
            end
         end
      end
   end

   // One sample and/or config strobe; the model is updated at the sampling point
   task automatic step(input bit vld, input int ch, input int val, input bit ld, input int f);
      bit ok;
      bit done = 1'b0;
      exp_t e;
      in_valid   = vld;
      in_chan    = CB'(ch);
      in         = W'(val);
      cfg_load   = ld;
      cfg_factor = FB'(f);
      for (int k = 0; k < 64 && !done; k++) begin
         @(negedge clk);
         ok = ld && (f >= 1) && (f <= 1024);
         if (!vld || in_ready) begin
            if (vld) begin
               acc_cnt++;
               if (!ok && ch < NCH) begin
                  if (cnt_m[ch] == factor_m - 1) begin
                     cnt_m[ch] = 0;
                     e.data = W'(val);
                     e.chan = CB'(ch);
                     e.cyc  = cyc + 1;
                     sb.push_back(e);
                  end else begin
                     cnt_m[ch]++;
                  end
               end
            end
            done = 1'b1;
         end
         if (ok) begin
            factor_m = f;
            for (int i = 0; i < NCH; i++) cnt_m[i] = 0;
         end
         @(posedge clk);
         #1;
         ld       = 1'b0;
         cfg_load = 1'b0;
      end
      if (!done) check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 300 && sb.size() > 0; k++) @(negedge clk);
      @(negedge clk);
      check(tag, sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int base, held;
      rst = 1'b1; cfg_factor = '0; cfg_load = 1'b0; in = '0; in_chan = '0;
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < NCH; i++) cnt_m[i] = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_cfg_error", cfg_error, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out", out, 0);
      check("rst_out_chan", out_chan, 0);
      @(posedge clk); #1;

      // Default factor 50, single channel, back-to-back
      chk_lat = 1'b1;
      base = out_cnt;
      for (int i = 0; i < 200; i++) step(1, 0, i, 0, 0);
      drain("drain_f50");
      check("f50_count", out_cnt - base, 4);
      chk_lat = 1'b0;

      // Out-of-range factors leave factor 50 in force
      base = err_seen;
      step(0, 0, 0, 1, 0);
      idle(1);
      step(0, 0, 0, 1, 1025);
      idle(2);
      check("cfg_err_pulses", err_seen - base, 2);
      base = out_cnt;
      for (int i = 0; i < 50; i++) step(1, 0, 300 + i, 0, 0);
      drain("drain_keep50");
      check("keep50_count", out_cnt - base, 1);

      // Interleaved channels at factor 3
      step(0, 0, 0, 1, 3);
      base = out_cnt;
      for (int i = 0; i < 12; i++)
         for (int c = 0; c < 4; c++) step(1, c, 100 * c + i, 0, 0);
      drain("drain_ilv");
      check("ilv_count", out_cnt - base, 16);

      // Backpressure at factor 1
      step(0, 0, 0, 1, 1);
      @(posedge clk); #1;
      out_ready = 1'b0;
      base = acc_cnt;
      held = out_cnt;
      fork
         begin
            for (int i = 0; i < 10; i++) step(1, 1, 1000 + i, 0, 0);
            bp_done = 1'b1;
         end
      join_none
      repeat (8) @(negedge clk);
      check("bp_in_ready_low", in_ready, 0);
      check("bp_accepts", acc_cnt - base, 4);
      check("bp_out_valid", out_valid, 1);
      check("bp_head", out, 1000);
      check("bp_no_pops", out_cnt - held, 0);
      repeat (3) @(negedge clk);
      check("bp_head_stable", out, 1000);
      check("bp_chan_stable", out_chan, 1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int k = 0; k < 400 && !bp_done; k++) @(negedge clk);
      check("bp_driver_done", bp_done, 1);
      drain("drain_bp");
      check("bp_count", out_cnt - held, 10);

      // Valid reconfiguration discards its same-cycle sample
      base = out_cnt;
      step(1, 0, 7777, 1, 2);
      for (int i = 1; i <= 4; i++) step(1, 0, i, 0, 0);
      drain("drain_cfg2");
      check("cfg2_count", out_cnt - base, 2);

      // Invalid channel samples are inert
      base = out_cnt;
      for (int i = 0; i < 8; i++) begin
         step(1, 0, i, 0, 0);
         step(1, 5 + (i % 3), 500 + i, 0, 0);
      end
      drain("drain_badch");
      check("badch_count", out_cnt - base, 4);

      // Mid-stream reset with queued samples and nonzero counters
      out_ready = 1'b0;
      for (int i = 0; i < 7; i++) step(1, 0, 900 + i, 0, 0);
      @(negedge clk);
      check("mr_out_valid_pre", out_valid, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      factor_m = 50;
      for (int i = 0; i < NCH; i++) cnt_m[i] = 0;
      @(negedge clk);
      check("mr_out_valid", out_valid, 0);
      check("mr_in_ready", in_ready, 1);
      check("mr_out", out, 0);
      check("mr_out_chan", out_chan, 0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      base = out_cnt;
      for (int i = 0; i < 60; i++) step(1, 0, 2000 + i, 0, 0);
      drain("drain_mr");
      check("mr_count", out_cnt - base, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
